// File: rtl/fft_tx_serializer_pkg.sv
// rtl/fft_tx_serializer_pkg.sv - shared frame defaults and serializer state encodings
package fft_tx_serializer_pkg;

    localparam int          DEF_N_BINS    = 64;
    localparam int          DEF_SAMPLE_W  = 18;
    localparam logic [7:0]  DEF_FRAME_HDR = 8'hA5;
    localparam int          BYTES_PER_BIN = 6;
    localparam int          EXT_W         = 24;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HEADER = 2'd1,
        ST_SEND   = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

endpackage

// File: rtl/fft_byte_mux.sv
// rtl/fft_byte_mux.sv - picks one byte of a sign-extended bin sample
module fft_byte_mux
    import fft_tx_serializer_pkg::*;
#(
    parameter int N_BINS   = DEF_N_BINS,
    parameter int SAMPLE_W = DEF_SAMPLE_W,
    parameter int BIN_W    = 6
) (
    input  logic [N_BINS*SAMPLE_W-1:0] real_buf,
    input  logic [N_BINS*SAMPLE_W-1:0] imag_buf,
    input  logic [BIN_W-1:0]           bin_idx,
    input  logic [2:0]                 byte_idx,
    output logic [7:0]                 byte_out
);

    logic                    is_imag;
    logic [1:0]              lane;
    logic [SAMPLE_W-1:0]     sample;
    logic signed [EXT_W-1:0] ext;

    always_comb begin
        is_imag = (byte_idx >= 3'd3);
        lane    = is_imag ? 2'(byte_idx - 3'd3) : byte_idx[1:0];
        sample  = is_imag ? imag_buf[SAMPLE_W*int'(bin_idx) +: SAMPLE_W]
                          : real_buf[SAMPLE_W*int'(bin_idx) +: SAMPLE_W];
        ext     = EXT_W'(signed'(sample));
        // lane 0 is the most significant byte of the 24-bit value
        case (lane)
            2'd0:    byte_out = ext[EXT_W-1 -: 8];
            2'd1:    byte_out = ext[EXT_W-9 -: 8];
            default: byte_out = ext[7:0];
        endcase
    end

endmodule

// File: rtl/fft_tx_serializer.sv
// rtl/fft_tx_serializer.sv - captures one FFT frame and streams it as header + 6 bytes per bin
module fft_tx_serializer
    import fft_tx_serializer_pkg::*;
#(
    parameter int         N_BINS    = DEF_N_BINS,
    parameter int         SAMPLE_W  = DEF_SAMPLE_W,
    parameter logic [7:0] FRAME_HDR = DEF_FRAME_HDR
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       dataReady,
    input  logic [N_BINS*SAMPLE_W-1:0] Yreal,
    input  logic [N_BINS*SAMPLE_W-1:0] Yimag,
    output logic [7:0]                 tx_data,
    output logic                       tx_valid,
    input  logic                       tx_ready,
    output logic                       busy,
    output logic                       frame_done,
    output logic                       overrun
);

    localparam int BIN_W = (N_BINS > 1) ? $clog2(N_BINS) : 1;

    state_t                     state, next_state;
    logic                       ready_q;
    logic                       rise;
    logic [2:0]                 byte_cnt;
    logic [BIN_W-1:0]           bin_cnt;
    logic [N_BINS*SAMPLE_W-1:0] real_buf;
    logic [N_BINS*SAMPLE_W-1:0] imag_buf;
    logic [7:0]                 mux_byte;
    logic                       last_in_bin;
    logic                       last_byte;

    assign rise        = dataReady && !ready_q;
    assign last_in_bin = (byte_cnt == 3'(BYTES_PER_BIN - 1));
    assign last_byte   = last_in_bin && (bin_cnt == BIN_W'(N_BINS - 1));

    fft_byte_mux #(
        .N_BINS   (N_BINS),
        .SAMPLE_W (SAMPLE_W),
        .BIN_W    (BIN_W)
    ) u_byte_mux (
        .real_buf (real_buf),
        .imag_buf (imag_buf),
        .bin_idx  (bin_cnt),
        .byte_idx (byte_cnt),
        .byte_out (mux_byte)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            ready_q  <= 1'b0;
            overrun  <= 1'b0;
            byte_cnt <= '0;
            bin_cnt  <= '0;
        end else begin
            state   <= next_state;
            ready_q <= dataReady;
            if (rise && state != ST_IDLE)
                overrun <= 1'b1;
            if (state == ST_IDLE && rise) begin
                byte_cnt <= '0;
                bin_cnt  <= '0;
            end else if (state == ST_SEND && tx_ready) begin
                if (last_in_bin) begin
                    byte_cnt <= '0;
                    bin_cnt  <= bin_cnt + 1'b1;
                end else begin
                    byte_cnt <= byte_cnt + 1'b1;
                end
            end
        end
    end

    // Buffers are only written on an accepted capture, so they hold through the whole frame.
    always_ff @(posedge clk) begin
        if (!rst && state == ST_IDLE && rise) begin
            real_buf <= Yreal;
            imag_buf <= Yimag;
        end
    end

    always_comb begin
        next_state = state;
        tx_data    = 8'h00;
        tx_valid   = 1'b0;
        busy       = 1'b0;
        frame_done = 1'b0;
        case (state)
            ST_IDLE: begin
                if (rise)
                    next_state = ST_HEADER;
            end
            ST_HEADER: begin
                busy     = 1'b1;
                tx_valid = 1'b1;
                tx_data  = FRAME_HDR;
                if (tx_ready)
                    next_state = ST_SEND;
            end
            ST_SEND: begin
                busy     = 1'b1;
                tx_valid = 1'b1;
                tx_data  = mux_byte;
                if (tx_ready && last_byte)
                    next_state = ST_DONE;
            end
            default: begin
                frame_done = 1'b1;
                next_state = ST_IDLE;
            end
        endcase
    end

endmodule
